// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  // Main sequencer states (4-bit encoding).
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  // Supported opcodes (instr[6:0]).
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Branch funct3 values handled by the BRANCH state.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Sign-extender immediate formats.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Fault causes.
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Result mux select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:     sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for register and immediate ALU instructions.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control,
  output logic       alu_illegal
);

  // funct7_5 only selects subtract for register-register ops; for addi it is an immediate bit.
  always_comb begin
    alu_control = ALU_ADD;
    alu_illegal = 1'b0;
    case (funct3)
      3'b000:  alu_control = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      3'b010:  alu_control = ALU_SLT;
      default: alu_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle RV32I core: state register, memory wait
// counter with timeout, fault capture and datapath control decode.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                 fault_q, fault_d;
  logic [1:0]           fault_code_q, fault_code_d;

  // Ungated enables straight from the state decode.
  logic mem_req_fsm, mem_write_fsm, ir_write_fsm, pc_write_fsm;
  logic reg_write_fsm, instr_done_fsm;

  logic [2:0] dec_alu_control;
  logic       dec_alu_illegal;
  logic       timeout_hit;
  logic       enter_mem_state;

  alu_decoder u_alu_decoder (
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu_control),
    .alu_illegal (dec_alu_illegal)
  );

  // The counter has already absorbed MEM_TIMEOUT wait cycles; one more miss faults.
  assign timeout_hit = (wait_cnt_q == TIMEOUT_CNT);

  // Next-state and control decode; Mealy terms only on ir/pc write and instr_done.
  always_comb begin
    state_d        = state_q;
    fault_code_d   = fault_code_q;
    mem_req_fsm    = 1'b0;
    mem_write_fsm  = 1'b0;
    adr_src        = 1'b0;
    ir_write_fsm   = 1'b0;
    pc_write_fsm   = 1'b0;
    reg_write_fsm  = 1'b0;
    instr_done_fsm = 1'b0;
    result_src     = RES_ALUOUT;
    alu_src_a      = SRCA_PC;
    alu_src_b      = SRCB_RS2;
    alu_control    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_fsm  = 1'b1;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU;
        ir_write_fsm = mem_ready;
        pc_write_fsm = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
              state_d = S_BRANCH;
            end else begin
              state_d      = S_TRAP;
              fault_code_d = FAULT_ILLEGAL;
            end
          end
          default: begin
            state_d      = S_TRAP;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_fsm = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_MEMWB: begin
        result_src     = RES_DATA;
        reg_write_fsm  = 1'b1;
        instr_done_fsm = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_fsm   = 1'b1;
        mem_write_fsm = 1'b1;
        adr_src       = 1'b1;
        if (mem_ready) begin
          instr_done_fsm = 1'b1;
          state_d        = S_FETCH;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alu_control = dec_alu_control;
        if (dec_alu_illegal) begin
          state_d      = S_TRAP;
          fault_code_d = FAULT_ILLEGAL;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        result_src     = RES_ALUOUT;
        reg_write_fsm  = 1'b1;
        instr_done_fsm = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut holds the target from DECODE; the ALU compares rs1 and rs2.
        alu_src_a      = SRCA_RS1;
        alu_src_b      = SRCB_RS2;
        alu_control    = ALU_SUB;
        result_src     = RES_ALUOUT;
        pc_write_fsm   = (funct3 == F3_BEQ) ? zero : !zero;
        instr_done_fsm = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Wait counter: restart on every new transfer, count only stalled request cycles.
  always_comb begin
    enter_mem_state = (state_d != state_q) &&
                      (state_d == S_FETCH || state_d == S_MEMREAD || state_d == S_MEMWRITE);
    wait_cnt_d = wait_cnt_q;
    if (enter_mem_state) begin
      wait_cnt_d = '0;
    end else if (mem_req_fsm && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end
  end

  // Fault flag is sticky from the moment TRAP is entered.
  always_comb begin
    fault_d = fault_q || (state_d == S_TRAP);
  end

  // State, counter and fault registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Enables are squashed while reset is held so an aborted instruction leaves no side effects.
  assign mem_req    = rst_n & mem_req_fsm;
  assign mem_write  = rst_n & mem_write_fsm;
  assign ir_write   = rst_n & ir_write_fsm;
  assign pc_write   = rst_n & pc_write_fsm;
  assign reg_write  = rst_n & reg_write_fsm;
  assign instr_done = rst_n & instr_done_fsm;

  assign imm_src    = imm_sel(op);
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one vector per clock cycle,
// expected control word (with don't-care mask) queued as each vector is driven.
module tb_multicycle_control;

  localparam int X = -1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, fault_code;
  logic [2:0] alu_control;
  logic       instr_done, fault;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .instr_done(instr_done),
    .fault(fault), .fault_code(fault_code)
  );

  // Word layout: mreq mw adr irw pcw rw rs[2] a[2] b[2] alu[3] imm[2] done fault fc[2]
  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zr;
    logic        rdy;
    logic [20:0] want;
    logic [20:0] care;
  } vec_t;

  typedef struct {
    string       name;
    logic [20:0] want;
    logic [20:0] care;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] cur_ins = '0;
  logic [1:0]  cur_imm = '0;
  logic [20:0] cur_want, cur_care;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic set_instr(input logic [31:0] w, input logic [1:0] imm);
    cur_ins = w;
    cur_imm = imm;
  endtask

  task automatic put(input int val, input int lsb, input int width);
    if (val >= 0) begin
      for (int k = 0; k < width; k++) begin
        cur_want[lsb+k] = val[k];
        cur_care[lsb+k] = 1'b1;
      end
    end
  endtask

  task automatic check_field(input string n, input int i, input logic [3:0] got,
                             input logic [3:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s (vector %0d): {mem_req,fault,fault_code} got %b, expected %b",
               n, i, got, want);
    end else begin
      $display("ok   %s (vector %0d): {mem_req,fault,fault_code} = %b", n, i, got);
    end
  endtask

  task automatic add(input string n, input logic rst, input logic zr, input logic rdy,
                     input int mreq, input int mw, input int adr, input int irw,
                     input int pcw, input int rw, input int rs, input int a, input int b,
                     input int alu, input int done, input int flt, input int fc);
    vec_t v;
    cur_want = '0;
    cur_care = '0;
    put(mreq, 20, 1); put(mw, 19, 1); put(adr, 18, 1); put(irw, 17, 1);
    put(pcw, 16, 1);  put(rw, 15, 1); put(rs, 13, 2);  put(a, 11, 2);
    put(b, 9, 2);     put(alu, 6, 3); put(int'(cur_imm), 4, 2);
    put(done, 3, 1);  put(flt, 2, 1); put(fc, 0, 2);
    v.name = n; v.rst = rst; v.op = cur_ins[6:0]; v.f3 = cur_ins[14:12];
    v.f7 = cur_ins[30]; v.zr = zr; v.rdy = rdy; v.want = cur_want; v.care = cur_care;
    vecs.push_back(v);
  endtask

  // Per-state expectations, written out from the control table.
  task automatic v_rst(input string n);
    add(n, 1'b0, 1'b1, 1'b1, 0, 0, X, 0, 0, 0, X, X, X, X, 0, 0, 0);
  endtask
  task automatic v_fetch(input string n, input int rdy);
    add(n, 1'b1, 1'b0, rdy[0], 1, 0, 0, rdy, rdy, 0, 2, 0, 2, 0, 0, 0, 0);
  endtask
  task automatic v_dec(input string n);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 0, X, 1, 1, 0, 0, 0, 0);
  endtask
  task automatic v_madr(input string n);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 0, X, 2, 1, 0, 0, 0, 0);
  endtask
  task automatic v_mrd(input string n, input int rdy);
    add(n, 1'b1, 1'b0, rdy[0], 1, 0, 1, 0, 0, 0, X, X, X, X, 0, 0, 0);
  endtask
  task automatic v_mwb(input string n);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 1, 1, X, X, X, 1, 0, 0);
  endtask
  task automatic v_mwr(input string n, input int rdy);
    add(n, 1'b1, 1'b0, rdy[0], 1, 1, 1, 0, 0, 0, X, X, X, X, rdy, 0, 0);
  endtask
  task automatic v_exr(input string n, input int alu);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 0, X, 2, 0, alu, 0, 0, 0);
  endtask
  task automatic v_exi(input string n, input int alu);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 0, X, 2, 1, alu, 0, 0, 0);
  endtask
  task automatic v_awb(input string n);
    add(n, 1'b1, 1'b0, 1'b0, 0, 0, X, 0, 0, 1, 0, X, X, X, 1, 0, 0);
  endtask
  task automatic v_br(input string n, input int zr, input int pcw);
    add(n, 1'b1, zr[0], 1'b0, 0, 0, X, 0, pcw, 0, 0, 2, 0, 1, 1, 0, 0);
  endtask
  task automatic v_trap(input string n, input int fc);
    add(n, 1'b1, 1'b1, 1'b1, 0, 0, X, 0, 0, 0, X, X, X, X, 0, 1, fc);
  endtask

  // Full ALU instruction: fetch, decode, execute, writeback.
  task automatic alu_instr(input string n, input logic [31:0] w, input int is_r, input int alu);
    set_instr(w, 2'b00);
    v_fetch({n, ".fetch"}, 1);
    v_dec({n, ".decode"});
    if (is_r != 0) v_exr({n, ".execr"}, alu);
    else           v_exi({n, ".execi"}, alu);
    v_awb({n, ".aluwb"});
  endtask

  task automatic branch_instr(input string n, input logic [31:0] w, input int zr, input int pcw);
    set_instr(w, 2'b10);
    v_fetch({n, ".fetch"}, 1);
    v_dec({n, ".decode"});
    v_br({n, ".branch"}, zr, pcw);
  endtask

  initial begin
    logic [20:0] act;
    sb_t         e;

    // Reset held for three cycles, then lw x5,8(x1) with memory always ready.
    set_instr(32'h00812283, 2'b00);
    for (int i = 0; i < 3; i++) v_rst("reset");
    v_fetch("lw.fetch", 1); v_dec("lw.decode"); v_madr("lw.memadr");
    v_mrd("lw.memread", 1); v_mwb("lw.memwb");

    // sw with three stalled cycles in MEMWRITE.
    set_instr(32'h0050A423, 2'b01);
    v_fetch("sw.fetch", 1); v_dec("sw.decode"); v_madr("sw.memadr");
    for (int i = 0; i < 3; i++) v_mwr("sw.memwrite_wait", 0);
    v_mwr("sw.memwrite_done", 1);

    // Branches: beq taken/not taken, bne taken/not taken.
    branch_instr("beq_z1", 32'h00208463, 1, 1);
    branch_instr("beq_z0", 32'h00208463, 0, 0);
    branch_instr("bne_z0", 32'h00209463, 0, 1);
    branch_instr("bne_z1", 32'h00209463, 1, 0);

    // Register and immediate ALU ops; addi with instr[30]=1 must still add.
    alu_instr("add",  32'h002080B3, 1, 0);
    alu_instr("sub",  32'h40208033, 1, 1);
    alu_instr("and",  32'h0020F0B3, 1, 2);
    alu_instr("or",   32'h0020E0B3, 1, 3);
    alu_instr("slt",  32'h0020A0B3, 1, 5);
    alu_instr("addi", 32'h00508093, 0, 0);
    alu_instr("addi_b30", 32'h40008093, 0, 0);
    alu_instr("ori",  32'h0050E093, 0, 3);

    // Reset lands in ALUWB: no reg_write may escape, then restart cleanly.
    set_instr(32'h002080B3, 2'b00);
    v_fetch("mid.fetch", 1); v_dec("mid.decode"); v_exr("mid.execr", 0);
    v_rst("mid.reset_in_aluwb");
    alu_instr("mid_again", 32'h002080B3, 1, 0);

    // Fetch stalls for exactly MEM_TIMEOUT cycles, then completes on the next: no fault.
    set_instr(32'h00812283, 2'b00);
    for (int i = 0; i < 15; i++) v_fetch("tmo_edge.fetch_wait", 0);
    v_fetch("tmo_edge.fetch_ready", 1);
    v_dec("tmo_edge.decode"); v_madr("tmo_edge.memadr");
    v_mrd("tmo_edge.memread_wait", 0); v_mrd("tmo_edge.memread_wait", 0);
    v_mrd("tmo_edge.memread_ready", 1); v_mwb("tmo_edge.memwb");

    // jal is unsupported: illegal-instruction trap, sticky until reset.
    set_instr(32'h0000006F, 2'b00);
    v_fetch("jal.fetch", 1); v_dec("jal.decode");
    for (int i = 0; i < 3; i++) v_trap("jal.trap", 1);
    v_rst("jal.reset"); v_rst("jal.reset");

    // Fetch never completes: counter reaches MEM_TIMEOUT with ready low -> timeout trap.
    set_instr(32'h00812283, 2'b00);
    for (int i = 0; i < 16; i++) v_fetch("tmo.fetch_wait", 0);
    for (int i = 0; i < 3; i++) v_trap("tmo.trap", 2);
    v_rst("tmo.reset");
    v_fetch("tmo.fetch_after_reset", 1);

    // Apply: drive on the falling edge, compare once inputs have settled.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst;
      op        = vecs[i].op;
      funct3    = vecs[i].f3;
      funct7_5  = vecs[i].f7;
      zero      = vecs[i].zr;
      mem_ready = vecs[i].rdy;
      sb.push_back('{name: vecs[i].name, want: vecs[i].want, care: vecs[i].care});
      #1;
      act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_control, imm_src, instr_done, fault, fault_code};
      e = sb.pop_front();
      n_vec++;
      if (((act ^ e.want) & e.care) != 21'd0) begin
        n_bad++;
        $display("FAIL %s (vector %0d): got %06h, expected %06h under care mask %06h",
                 e.name, i, act, e.want, e.care);
      end else begin
        $display("ok   %s (vector %0d): %06h", e.name, i, act);
      end
      if (e.name == "reset") begin
        check_field("reset.state", i, {mem_req, fault, fault_code}, 4'b0000);
      end
      if (e.name == "tmo.trap") begin
        check_field("tmo.expired_wait", i, {mem_req, fault, fault_code}, 4'b0110);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
